// File: rtl/ex_stage_pkg.sv
// Shared constants for the execute stage: RV32I/M opcode and funct fields,
// common zero/enable values and the divider FSM state encoding.
package ex_stage_pkg;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Slt    = 3'b010;
  localparam logic [2:0] F3Sltu   = 3'b011;
  localparam logic [2:0] F3Xor    = 3'b100;
  localparam logic [2:0] F3Sr     = 3'b101;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  localparam logic [6:0] F7Base   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;
  localparam logic [6:0] F7MulDiv = 7'b0000001;

  localparam logic [31:0] INST_NOP     = 32'h0000_0013;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [4:0]  ZeroReg      = 5'd0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;

  typedef enum logic [1:0] {DivIdle, DivBusy, DivDone} div_state_e;

  // op[0]: unsigned, op[1]: remainder -- matches funct3[1:0] of DIV/DIVU/REM/REMU
  typedef logic [1:0] div_op_t;

endpackage

// File: rtl/ex_div.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU; works on magnitudes and
// sign-corrects on the way out. Divide-by-zero and overflow skip straight to DONE.
module ex_div
  import ex_stage_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  div_op_t         op_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            reg_wen_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_wen_o
);

  localparam int unsigned CntW = $clog2(DIV_CYCLES);

  div_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic [XLEN-1:0] quot_q, rem_q, divisor_q;
  logic            neg_quot_q, neg_rem_q, rem_sel_q;

  logic            is_signed;
  logic [XLEN-1:0] dividend_abs, divisor_abs;
  logic [XLEN:0]   partial, diff;
  logic [XLEN-1:0] step_rem, step_quot;

  assign is_signed    = ~op_i[0];
  assign dividend_abs = (is_signed && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
  assign divisor_abs  = (is_signed && divisor_i[XLEN-1]) ? -divisor_i : divisor_i;

  // Shift the next dividend bit into the partial remainder and try a subtract
  assign partial   = {rem_q, quot_q[XLEN-1]};
  assign diff      = partial - {1'b0, divisor_q};
  assign step_rem  = diff[XLEN] ? partial[XLEN-1:0] : diff[XLEN-1:0];
  assign step_quot = {quot_q[XLEN-2:0], ~diff[XLEN]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DivIdle;
      cnt_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      rem_sel_q  <= 1'b0;
      rd_addr_o  <= ZeroReg;
      rd_wen_o   <= WriteDisable;
    end else begin
      unique case (state_q)
        DivIdle: begin
          if (start_i) begin
            rd_addr_o <= rd_addr_i;
            rd_wen_o  <= reg_wen_i;
            rem_sel_q <= op_i[1];
            cnt_q     <= '0;
            if (divisor_i == '0) begin
              quot_q     <= '1;
              rem_q      <= dividend_i;
              neg_quot_q <= 1'b0;
              neg_rem_q  <= 1'b0;
              state_q    <= DivDone;
            end else if (is_signed && dividend_i == {1'b1, {(XLEN-1){1'b0}}} &&
                         divisor_i == '1) begin
              quot_q     <= {1'b1, {(XLEN-1){1'b0}}};
              rem_q      <= '0;
              neg_quot_q <= 1'b0;
              neg_rem_q  <= 1'b0;
              state_q    <= DivDone;
            end else begin
              quot_q     <= dividend_abs;
              rem_q      <= '0;
              divisor_q  <= divisor_abs;
              neg_quot_q <= is_signed & (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]);
              neg_rem_q  <= is_signed & dividend_i[XLEN-1];
              state_q    <= DivBusy;
            end
          end
        end
        DivBusy: begin
          rem_q  <= step_rem;
          quot_q <= step_quot;
          cnt_q  <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(DIV_CYCLES - 1)) state_q <= DivDone;
        end
        DivDone: state_q <= DivIdle;
        default: state_q <= DivIdle;
      endcase
    end
  end

  assign busy_o   = (state_q == DivBusy);
  assign done_o   = (state_q == DivDone);
  assign result_o = rem_sel_q ? (neg_rem_q ? -rem_q : rem_q)
                              : (neg_quot_q ? -quot_q : quot_q);

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: single-cycle ALU, branch and jump resolution, with
// RV32M divides delegated to ex_div while the pipeline is held.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            reg_wen_i,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_wen_o,
  output logic [XLEN-1:0] jump_addr_o,
  output logic            jump_en_o,
  output logic            hold_flag_o
);

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [XLEN-1:0] b_imm, j_imm, pc_plus4, sum12, alu_res, res;
  logic signed [XLEN-1:0] sra_res;
  logic            alt, br_taken, wen, jmp;
  logic [XLEN-1:0] jaddr;

  logic            is_div, div_start, div_busy, div_done, div_wen;
  logic [XLEN-1:0] div_result;
  logic [4:0]      div_rd;

  assign opcode   = inst_i[6:0];
  assign funct3   = inst_i[14:12];
  assign funct7   = inst_i[31:25];
  assign b_imm    = {{(XLEN-12){inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign j_imm    = {{(XLEN-20){inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign pc_plus4 = inst_addr_i + XLEN'(4);
  assign sum12    = op1_i + op2_i;
  assign sra_res  = $signed(op1_i) >>> op2_i[4:0];

  // Immediate forms never subtract; inst[30] only selects SRAI there
  assign alt = (opcode == OpcOp) ? inst_i[30] : ((funct3 == F3Sr) & inst_i[30]);

  always_comb begin
    unique case (funct3)
      F3AddSub: alu_res = alt ? (op1_i - op2_i) : sum12;
      F3Sll:    alu_res = op1_i << op2_i[4:0];
      F3Slt:    alu_res = {{(XLEN-1){1'b0}}, $signed(op1_i) < $signed(op2_i)};
      F3Sltu:   alu_res = {{(XLEN-1){1'b0}}, op1_i < op2_i};
      F3Xor:    alu_res = op1_i ^ op2_i;
      F3Sr:     alu_res = alt ? sra_res : (op1_i >> op2_i[4:0]);
      F3Or:     alu_res = op1_i | op2_i;
      F3And:    alu_res = op1_i & op2_i;
      default:  alu_res = ZeroWord;
    endcase
  end

  always_comb begin
    case (funct3)
      F3Beq:   br_taken = (op1_i == op2_i);
      F3Bne:   br_taken = (op1_i != op2_i);
      F3Blt:   br_taken = ($signed(op1_i) < $signed(op2_i));
      F3Bge:   br_taken = ($signed(op1_i) >= $signed(op2_i));
      F3Bltu:  br_taken = (op1_i < op2_i);
      F3Bgeu:  br_taken = (op1_i >= op2_i);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    res   = ZeroWord;
    wen   = WriteDisable;
    jmp   = 1'b0;
    jaddr = ZeroWord;
    case (opcode)
      OpcOp: begin
        if (funct7 == F7Base ||
            (funct7 == F7Alt && (funct3 == F3AddSub || funct3 == F3Sr))) begin
          res = alu_res;
          wen = reg_wen_i;
        end
      end
      OpcOpImm: begin
        res = alu_res;
        wen = reg_wen_i;
      end
      OpcLui: begin
        res = sum12;
        wen = reg_wen_i;
      end
      OpcAuipc: begin
        res = inst_addr_i + op2_i;
        wen = reg_wen_i;
      end
      OpcBranch: begin
        if (br_taken) begin
          jmp   = 1'b1;
          jaddr = inst_addr_i + b_imm;
        end
      end
      OpcJal: begin
        jmp   = 1'b1;
        jaddr = inst_addr_i + j_imm;
        res   = pc_plus4;
        wen   = reg_wen_i;
      end
      OpcJalr: begin
        jmp   = 1'b1;
        jaddr = {sum12[XLEN-1:1], 1'b0};
        res   = pc_plus4;
        wen   = reg_wen_i;
      end
      default: ;
    endcase
  end

  assign is_div    = (opcode == OpcOp) && (funct7 == F7MulDiv) && funct3[2];
  // DONE still sees the same divide on inst_i; only a fresh IDLE may start
  assign div_start = is_div & ~div_busy & ~div_done;

  ex_div #(
    .XLEN      (XLEN),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_ex_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (div_start),
    .dividend_i(op1_i),
    .divisor_i (op2_i),
    .op_i      (funct3[1:0]),
    .rd_addr_i (rd_addr_i),
    .reg_wen_i (reg_wen_i),
    .busy_o    (div_busy),
    .done_o    (div_done),
    .result_o  (div_result),
    .rd_addr_o (div_rd),
    .rd_wen_o  (div_wen)
  );

  always_comb begin
    rd_addr_o   = ZeroReg;
    rd_data_o   = ZeroWord;
    rd_wen_o    = WriteDisable;
    jump_addr_o = ZeroWord;
    jump_en_o   = 1'b0;
    hold_flag_o = 1'b0;
    if (rst_n) begin
      if (div_done) begin
        rd_addr_o = div_rd;
        rd_data_o = div_result;
        rd_wen_o  = div_wen;
      end else begin
        rd_addr_o   = rd_addr_i;
        rd_data_o   = res;
        hold_flag_o = div_start | div_busy;
        if (!div_busy) begin
          rd_wen_o    = wen;
          jump_en_o   = jmp;
          jump_addr_o = jaddr;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Randomised scoreboard bench for ex_stage: a driver issues instructions and
// queues expected writes/redirects; a monitor matches them as the DUT emits them.
module tb_ex_stage;

  localparam logic [6:0] OP    = 7'b0110011;
  localparam logic [6:0] OPI   = 7'b0010011;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = NOP, pc = '0, op1 = '0, op2 = '0;
  logic [4:0]  rd = '0;
  logic        wen = 1'b0;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o, jump_addr_o;
  logic        rd_wen_o, jump_en_o, hold_flag_o;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_i     (inst),
    .inst_addr_i(pc),
    .op1_i      (op1),
    .op2_i      (op2),
    .rd_addr_i  (rd),
    .reg_wen_i  (wen),
    .rd_addr_o  (rd_addr_o),
    .rd_data_o  (rd_data_o),
    .rd_wen_o   (rd_wen_o),
    .jump_addr_o(jump_addr_o),
    .jump_en_o  (jump_en_o),
    .hold_flag_o(hold_flag_o)
  );

  int n_checks = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;
  wr_t         wq[$];
  logic [31:0] jq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rdf);
    return {f7, 5'd2, 5'd1, f3, rdf, OP};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                        input logic [4:0] rdf, input logic [6:0] opc);
    return {imm, 5'd1, f3, rdf, opc};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [2:0] f3);
    return {off[12], off[10:5], 5'd2, 5'd1, f3, off[4:1], off[11], BR};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] off, input logic [4:0] rdf);
    return {off[20], off[10:1], off[11], off[19:12], rdf, JAL};
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'(sa >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // Division by arithmetic on 64-bit integers; the overflow case falls out naturally
  function automatic logic [31:0] div_ref(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    sa = op[0] ? longint'({32'd0, a}) : longint'($signed(a));
    sb = op[0] ? longint'({32'd0, b}) : longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  task automatic model(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic we, output logic do_wr,
                       output logic [31:0] wd, output logic do_j, output logic [31:0] ja,
                       output int hold);
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] bimm, jimm;
    logic        tk;
    f3    = i[14:12];
    f7    = i[31:25];
    bimm  = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    jimm  = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    do_wr = 1'b0; wd = '0; do_j = 1'b0; ja = '0; hold = 0;
    case (i[6:0])
      OP: begin
        if (f7 == 7'h01) begin
          if (f3[2]) begin
            do_wr = we;
            wd    = div_ref(f3[1:0], a, b);
            hold  = (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
          end
        end else if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
          do_wr = we;
          wd    = alu_ref(f3, f7[5], a, b);
        end
      end
      OPI:   begin do_wr = we; wd = alu_ref(f3, (f3 == 3'd5) && i[30], a, b); end
      LUI:   begin do_wr = we; wd = b; end
      AUIPC: begin do_wr = we; wd = p + b; end
      BR: begin
        case (f3)
          3'd0:    tk = (a == b);
          3'd1:    tk = (a != b);
          3'd4:    tk = ($signed(a) < $signed(b));
          3'd5:    tk = ($signed(a) >= $signed(b));
          3'd6:    tk = (a < b);
          default: tk = (a >= b);
        endcase
        do_j = tk;
        ja   = tk ? p + bimm : 32'd0;
      end
      JAL:  begin do_wr = we; wd = p + 4; do_j = 1'b1; ja = p + jimm; end
      JALR: begin do_wr = we; wd = p + 4; do_j = 1'b1; ja = (a + b) & 32'hFFFF_FFFE; end
      default: ;
    endcase
  endtask

  // Holds the instruction on the inputs for as long as the DUT requests a stall
  task automatic issue(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [4:0] r, input logic we);
    logic        do_wr, do_j;
    logic [31:0] wd, ja;
    int          exp_hold, holds;
    model(i, a, b, p, we, do_wr, wd, do_j, ja, exp_hold);
    if (do_wr) wq.push_back('{rd: r, data: wd});
    if (do_j) jq.push_back(ja);
    @(posedge clk); #1;
    inst = i; op1 = a; op2 = b; pc = p; rd = r; wen = we;
    @(negedge clk);
    if (i[6:0] == BR && !do_j) check("br_not_taken_addr", jump_addr_o, 32'd0);
    holds = 0;
    while (hold_flag_o && holds < 100) begin
      holds++;
      @(negedge clk);
    end
    check("hold_cycles", 32'(holds), 32'(exp_hold));
  endtask

  initial begin : monitor
    wr_t         w;
    logic [31:0] ja;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rd_wen_o) begin
          if (wq.size() == 0) begin
            n_checks++;
            $display("FAIL spurious_write: actual rd=%0d data=0x%08h required no write",
                     rd_addr_o, rd_data_o);
          end else begin
            w = wq.pop_front();
            check("wr_rd", {27'd0, rd_addr_o}, {27'd0, w.rd});
            check("wr_data", rd_data_o, w.data);
          end
        end
        if (jump_en_o) begin
          if (jq.size() == 0) begin
            n_checks++;
            $display("FAIL spurious_jump: actual addr=0x%08h required no jump", jump_addr_o);
          end else begin
            ja = jq.pop_front();
            check("jump_addr", jump_addr_o, ja);
          end
        end
      end
    end
  end

  initial begin : driver
    logic [31:0] i, a, b, p;
    logic [11:0] imm;
    logic [19:0] imm20;
    logic [12:0] boff;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  r;
    logic        we;
    int          k;

    // Reset with a live ADD on the inputs: every output must still read zero
    inst = enc_r(7'h00, 3'd0, 5'd3); op1 = 32'h7FFF_FFFF; op2 = 32'd1; rd = 5'd3; wen = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rd_wen", {31'd0, rd_wen_o}, 32'd0);
    check("rst_rd_data", rd_data_o, 32'd0);
    check("rst_rd_addr", {27'd0, rd_addr_o}, 32'd0);
    check("rst_jump_en", {31'd0, jump_en_o}, 32'd0);
    check("rst_hold", {31'd0, hold_flag_o}, 32'd0);
    inst = NOP; wen = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    issue(enc_r(7'h00, 3'd0, 5'd3), 32'h7FFF_FFFF, 32'd1, 32'h0, 5'd3, 1'b1);
    issue(enc_b(13'h1FF8, 3'd0), 32'd5, 32'd5, 32'h100, 5'd0, 1'b0);
    issue(enc_b(13'h1FF8, 3'd0), 32'd5, 32'd6, 32'h100, 5'd0, 1'b0);
    issue(enc_i(12'd4, 3'd0, 5'd1, JALR), 32'h203, 32'd4, 32'h40, 5'd1, 1'b1);
    issue(enc_r(7'h01, 3'd4, 5'd5), 32'hFFFF_FFF9, 32'd2, 32'h0, 5'd5, 1'b1);
    issue(enc_r(7'h01, 3'd6, 5'd5), 32'hFFFF_FFF9, 32'd2, 32'h0, 5'd5, 1'b1);
    issue(enc_r(7'h01, 3'd5, 5'd6), 32'hFFFF_FFF9, 32'd2, 32'h0, 5'd6, 1'b1);
    issue(enc_r(7'h01, 3'd5, 5'd7), 32'd10, 32'd0, 32'h0, 5'd7, 1'b1);
    issue(enc_r(7'h01, 3'd7, 5'd7), 32'd10, 32'd0, 32'h0, 5'd7, 1'b1);
    issue(enc_r(7'h01, 3'd4, 5'd8), 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 5'd8, 1'b1);
    issue(enc_r(7'h01, 3'd6, 5'd8), 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 5'd8, 1'b1);
    issue(NOP, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);

    // Reset in the 10th BUSY cycle: the aborted divide must never write
    @(posedge clk); #1;
    inst = enc_r(7'h01, 3'd4, 5'd9); op1 = 32'd100; op2 = 32'd7; rd = 5'd9; wen = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("hold_before_reset", {31'd0, hold_flag_o}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check("hold_in_reset", {31'd0, hold_flag_o}, 32'd0);
    check("wen_in_reset", {31'd0, rd_wen_o}, 32'd0);
    inst = NOP; wen = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    issue(enc_r(7'h01, 3'd4, 5'd9), 32'd100, 32'd7, 32'h0, 5'd9, 1'b1);

    for (int n = 0; n < 300; n++) begin
      k  = int'($urandom_range(0, 9));
      f3 = 3'($urandom);
      r  = 5'($urandom);
      we = ($urandom_range(0, 9) != 0);
      a  = $urandom;
      b  = $urandom;
      p  = $urandom & 32'hFFFF_FFFC;
      case (k)
        2, 3: begin
          imm = 12'($urandom);
          if (f3 == 3'd1) imm[11:5] = 7'h00;
          if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
          i = enc_i(imm, f3, r, OPI);
          b = {{20{imm[11]}}, imm};
        end
        4: begin
          imm20 = 20'($urandom);
          if ($urandom_range(0, 1) == 1) begin
            i = {imm20, r, LUI};
            a = 32'd0;
          end else begin
            i = {imm20, r, AUIPC};
          end
          b = {imm20, 12'd0};
        end
        5: begin
          if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd0;
          boff = 13'($urandom) & 13'h1FFE;
          i = enc_b(boff, f3);
          if ($urandom_range(0, 2) == 0) b = a;
        end
        6: begin
          if ($urandom_range(0, 1) == 1) begin
            i = enc_j(21'($urandom) & 21'h1FFFFE, r);
          end else begin
            imm = 12'($urandom);
            i = enc_i(imm, 3'd0, r, JALR);
            b = {{20{imm[11]}}, imm};
          end
        end
        7: begin
          i = enc_r(7'h01, {1'b1, f3[1:0]}, r);
          case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 16));
            3: b = ~32'($urandom_range(0, 15));
            default: ;
          endcase
        end
        8: begin
          if ($urandom_range(0, 1) == 1) i = enc_r(7'h01, {1'b0, f3[1:0]}, r);
          else i = {25'($urandom), 7'b0001111};
        end
        default: begin
          f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
          i = enc_r(f7, f3, r);
          if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 31));
        end
      endcase
      issue(i, a, b, p, r, we);
    end

    issue(NOP, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    repeat (5) @(negedge clk);
    check("pending_writes", 32'(wq.size()), 32'd0);
    check("pending_jumps", 32'(jq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
